// File: rtl/load_scoreboard.sv
// load_scoreboard: decode-stage scoreboard for loads in flight to the LSU.
// Each pending bit marks a destination register that a load will write
// later. Decode stalls on a read or overwrite of such a register.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a response or
// kill releases its register for the hazard check in the same cycle.
//
// Handshake: RespValid and KillValid are single-cycle strobes and have no
// ready signal. The scoreboard consumes them on every rising edge. A strobe
// that names a register with no pending bit changes no state and sets the
// sticky SpuriousResp flag.
module load_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic             RS1UsedD,
    input  logic             RS2UsedD,
    input  logic [4:0]       RD_D,
    input  logic             RegWriteD,
    input  logic             LoadD,
    input  logic             IssueValidD,
    input  logic             RespValid,
    input  logic [4:0]       RespRD,
    input  logic             KillValid,
    input  logic [4:0]       KillRD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic [31:0]      Pending,
    output logic [CNT_W-1:0] Outstanding,
    output logic             SbFull,
    output logic             SpuriousResp
);

    logic [31:0]      pending_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spur_q;

    logic [31:0]      clr_mask;
    logic [31:0]      set_mask;
    logic [31:0]      eff;
    logic [1:0]       clr_cnt;
    logic             resp_hit;
    logic             kill_hit;
    logic             spur_now;
    logic             full;
    logic             hazard;
    logic             accept;
    logic [CNT_W-1:0] cnt_d;

    // Release mask from responses and kills that hit pending registers.
    // Strobes that hit nothing, and a response and kill that name the same
    // register, are flagged as spurious.
    always_comb begin
        resp_hit = RespValid & pending_q[RespRD];
        kill_hit = KillValid & pending_q[KillRD];
        clr_mask = ({32{resp_hit}} & (32'd1 << RespRD)) |
                   ({32{kill_hit}} & (32'd1 << KillRD));
        clr_mask[0] = 1'b0;
        if (resp_hit && kill_hit && (RespRD != KillRD))
            clr_cnt = 2'd2;
        else if (resp_hit || kill_hit)
            clr_cnt = 2'd1;
        else
            clr_cnt = 2'd0;
        spur_now = (RespValid & ~pending_q[RespRD]) |
                   (KillValid & ~pending_q[KillRD]) |
                   (RespValid & KillValid & (RespRD == KillRD));
    end

`ifdef WB_BYPASS_EN
    // A register released this cycle is already visible through the
    // register-file write-through, so it no longer blocks decode.
    assign eff = pending_q & ~clr_mask;
`else
    assign eff = pending_q;
`endif

    assign full = (cnt_q == CNT_W'(MAX_OUTSTANDING));

    // Hazard detection on RAW, WAW and a load that finds no free slot.
    // Accept a load once decode is clear of all of these.
    always_comb begin
        hazard = IssueValidD & (
                 (RS1UsedD  & (RS1_D != 5'd0) & eff[RS1_D]) |
                 (RS2UsedD  & (RS2_D != 5'd0) & eff[RS2_D]) |
                 (RegWriteD & (RD_D  != 5'd0) & eff[RD_D])  |
                 (LoadD & full & ~(|clr_mask)));
        accept   = IssueValidD & LoadD & RegWriteD & (RD_D != 5'd0) & ~hazard;
        set_mask = accept ? (32'd1 << RD_D) : 32'd0;
        cnt_d    = cnt_q + CNT_W'(accept) - CNT_W'(clr_cnt);
    end

    // Scoreboard state. A set wins over a clear of the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 32'd0;
            cnt_q     <= '0;
            spur_q    <= 1'b0;
        end else begin
            pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
            cnt_q     <= cnt_d;
            spur_q    <= spur_q | spur_now;
        end
    end

    // Stalls are combinational and held low for as long as reset is low.
    assign StallF       = hazard & rst;
    assign StallD       = hazard & rst;
    assign FlushE       = hazard & rst;
    assign Pending      = pending_q;
    assign Outstanding  = cnt_q;
    assign SbFull       = full;
    assign SpuriousResp = spur_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// tb_load_scoreboard: directed scenarios followed by random traffic. The
// reference model keeps the in-flight loads as a queue of register numbers.
module tb_load_scoreboard;

    localparam int MAX_OUT = 4;
    localparam int CNT_W   = 3;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [4:0]       rs1, rs2, rd, resp_rd, kill_rd;
    logic             rs1_used, rs2_used, reg_write, load, issue_valid;
    logic             resp_valid, kill_valid;
    logic             stall_f, stall_d, flush_e;
    logic [31:0]      pending;
    logic [CNT_W-1:0] outstanding;
    logic             sb_full, spurious;

    int n_checks;
    int n_fail;
    int inflight[$];
    bit m_spur;

    load_scoreboard #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(rs1), .RS2_D(rs2), .RS1UsedD(rs1_used), .RS2UsedD(rs2_used),
        .RD_D(rd), .RegWriteD(reg_write), .LoadD(load), .IssueValidD(issue_valid),
        .RespValid(resp_valid), .RespRD(resp_rd),
        .KillValid(kill_valid), .KillRD(kill_rd),
        .StallF(stall_f), .StallD(stall_d), .FlushE(flush_e),
        .Pending(pending), .Outstanding(outstanding),
        .SbFull(sb_full), .SpuriousResp(spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_flight(input int r);
        foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void drop(input int r);
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i] == r) begin
                inflight.delete(i);
                return;
            end
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = 32'd0;
        foreach (inflight[i]) v[inflight[i]] = 1'b1;
        return v;
    endfunction

    function automatic bit released(input int r);
        return (resp_valid && int'(resp_rd) == r && in_flight(r)) ||
               (kill_valid && int'(kill_rd) == r && in_flight(r));
    endfunction

    function automatic bit blocks(input int r);
        return r != 0 && in_flight(r) && !(BYPASS && released(r));
    endfunction

    function automatic bit model_hazard();
        bit any_release;
        any_release = (resp_valid && in_flight(resp_rd)) || (kill_valid && in_flight(kill_rd));
        return issue_valid && ((rs1_used && blocks(rs1)) ||
                               (rs2_used && blocks(rs2)) ||
                               (reg_write && blocks(rd)) ||
                               (load && inflight.size() == MAX_OUT && !any_release));
    endfunction

    task automatic set_idle();
        issue_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        rs1_used = 0; rs2_used = 0; reg_write = 0; load = 0;
        resp_valid = 0; resp_rd = 0; kill_valid = 0; kill_rd = 0;
    endtask

    task automatic instr(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int d, input bit w, input bit l);
        issue_valid = v; rs1 = 5'(r1); rs1_used = u1; rs2 = 5'(r2); rs2_used = u2;
        rd = 5'(d); reg_write = w; load = l;
    endtask

    // Called just after a falling edge with inputs driven: compare, then
    // advance the model across the rising edge.
    task automatic step(input string tag);
        bit hz, resp_hit, kill_hit;
        #1;
        hz = model_hazard();
        check({tag, ".stall_f"}, 32'(stall_f), 32'(hz));
        check({tag, ".stall_d"}, 32'(stall_d), 32'(hz));
        check({tag, ".flush_e"}, 32'(flush_e), 32'(hz));
        check({tag, ".pending"}, pending, model_vec());
        check({tag, ".outstanding"}, 32'(outstanding), 32'(inflight.size()));
        check({tag, ".sb_full"}, 32'(sb_full), 32'(inflight.size() == MAX_OUT));
        check({tag, ".spurious"}, 32'(spurious), 32'(m_spur));
        @(posedge clk);
        resp_hit = resp_valid && in_flight(resp_rd);
        kill_hit = kill_valid && in_flight(kill_rd);
        if ((resp_valid && !resp_hit) || (kill_valid && !kill_hit) ||
            (resp_valid && kill_valid && resp_rd == kill_rd))
            m_spur = 1'b1;
        if (resp_hit) drop(resp_rd);
        if (kill_hit) drop(kill_rd);
        if (issue_valid && load && reg_write && rd != 0 && !hz) inflight.push_back(rd);
        @(negedge clk);
    endtask

    // Asynchronous reset taken away from any clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, ".rst_stall"}, 32'(stall_f | stall_d | flush_e), 32'd0);
        check({tag, ".rst_pending"}, pending, 32'd0);
        check({tag, ".rst_outstanding"}, 32'(outstanding), 32'd0);
        check({tag, ".rst_spurious"}, 32'(spurious), 32'd0);
        inflight.delete();
        m_spur = 1'b0;
        set_idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_spur   = 0;
        set_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.pending", pending, 32'd0);
        check("reset.outstanding", 32'(outstanding), 32'd0);
        check("reset.spurious", 32'(spurious), 32'd0);
        rst = 1'b1;

        // RAW on a load destination, released by a response.
        instr(1, 0, 0, 0, 0, 5, 1, 1); step("raw.load5");
        instr(1, 5, 1, 0, 0, 10, 1, 0);
        repeat (3) step("raw.add");
        check("raw.pending5", pending, 32'h0000_0020);
        resp_valid = 1; resp_rd = 5; step("raw.resp");
        resp_valid = 0; step("raw.after");

        // Load to x0 and a consumer of x0.
        instr(1, 0, 0, 0, 0, 0, 1, 1); step("x0.load");
        instr(1, 0, 1, 0, 1, 11, 1, 0); step("x0.use");

        // Fill, block a fifth load, then admit it on a response.
        for (int r = 1; r <= 4; r++) begin
            instr(1, 0, 0, 0, 0, r, 1, 1); step("fill");
        end
        check("fill.sb_full", 32'(sb_full), 32'd1);
        instr(1, 0, 0, 0, 0, 6, 1, 1);
        repeat (2) step("full.load6");
        resp_valid = 1; resp_rd = 2; step("full.resp2");
        set_idle(); step("full.idle");
        check("full.pending", pending, 32'h0000_005A);
        check("full.outstanding", 32'(outstanding), 32'd4);

        // Kill and response clearing two registers on one edge.
        resp_valid = 1; resp_rd = 1; step("dual.resp1");
        resp_rd = 4; step("dual.resp4");
        set_idle(); instr(1, 0, 0, 0, 0, 7, 1, 1); step("dual.load7");
        set_idle(); resp_valid = 1; resp_rd = 3; kill_valid = 1; kill_rd = 7;
        step("dual.clear");
        set_idle(); step("dual.idle");
        check("dual.outstanding", 32'(outstanding), 32'd1);

        // WAW on x9, then a spurious response to x12.
        instr(1, 0, 0, 0, 0, 9, 1, 1); step("waw.load9");
        instr(1, 0, 0, 0, 0, 9, 1, 0);
        repeat (2) step("waw.write9");
        resp_valid = 1; resp_rd = 9; step("waw.resp");
        set_idle(); step("waw.after");
        resp_valid = 1; resp_rd = 12; step("spur.resp12");
        set_idle(); step("spur.hold");
        check("spur.sticky", 32'(spurious), 32'd1);
        resp_valid = 1; resp_rd = 6; step("spur.drain6");
        set_idle();

        // Asynchronous reset mid-stall with three loads pending.
        for (int r = 1; r <= 3; r++) begin
            instr(1, 0, 0, 0, 0, r, 1, 1); step("areset.load");
        end
        instr(1, 1, 1, 2, 1, 13, 1, 0);
        #1;
        check("areset.stall_before", 32'(stall_f), 32'd1);
        do_reset("areset");
        resp_valid = 1; resp_rd = 2; step("areset.late_resp");
        set_idle(); step("areset.idle");

        // Random traffic.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            set_idle();
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand");
            end else begin
                instr($urandom_range(0, 3) != 0,
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
                if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                    resp_valid = 1;
                    resp_rd = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
                end else if ($urandom_range(0, 59) == 0) begin
                    resp_valid = 1;
                    resp_rd = 5'($urandom_range(0, 31));
                end
                if (inflight.size() > 0 && $urandom_range(0, 5) == 0) begin
                    kill_valid = 1;
                    kill_rd = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
                end
                step("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
